// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and helpers for the PWM generator slice:
//            default prescaler divide, default counter width, channel count.
// Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // Number of PWM output channels driven by the block
  localparam int NUM_CH      = 16;

  // Default clk cycles per PWM counter step
  localparam int CLK_DIV_DEF = 3000;

  // Default PWM counter width; one period is 2^CNT_W steps
  localparam int CNT_W_DEF   = 8;

  // Prescaler register width; a divide of 1 still needs a 1-bit register
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module   : pwm_timebase
// Purpose  : Shared PWM time base. A prescaler divides clk by CLK_DIV to form
//            a step strobe; the PWM counter advances once per strobe and
//            wraps every 2^CNT_W steps. period_start marks the strobe that
//            moves the counter back to 0.
// Revision : 1.0  initial release
// ============================================================================
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             period_start
);

  localparam int                     c_PRESC_W   = presc_width(CLK_DIV);
  localparam logic [c_PRESC_W-1:0]   c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]       c_CNT_MAX   = '1;

  logic [c_PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_step;

  // With CLK_DIV=1 the prescaler sits at 0 and the strobe is high every cycle
  assign w_step = (r_presc == c_PRESC_MAX);

  // Prescaler: count 0..CLK_DIV-1, restart after the strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_step) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_PRESC_W'(1);
    end
  end

  // PWM counter: advance once per step strobe, natural wrap at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Counter is 0 in reset, so this pulse is low while rst_n is asserted
  assign period_start = w_step && (r_cnt == c_CNT_MAX);
  assign cnt          = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_generator
// Purpose  : 16-channel PWM generator. All PWM-mode channels share one time
//            base and one active duty value, so they stay phase-aligned.
//            Each channel is forced low, forced high, or follows the PWM
//            waveform according to en_out/en_pwm; outputs are registered.
// Config   : PWM_SHADOW_DUTY_EN - when defined, duty is loaded into the
//            active duty register only on the period_start cycle; otherwise
//            it is loaded every clk and takes effect mid-period.
// Revision : 1.0  initial release
// ============================================================================
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic [CNT_W-1:0]  duty,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0] c_DUTY_FULL = '1;

  logic [CNT_W-1:0]  w_cnt;
  logic              w_period_start;
  logic [CNT_W-1:0]  r_duty_act;
  logic              w_pwm_raw;
  logic [NUM_CH-1:0] w_chan;
  logic [NUM_CH-1:0] r_pwm_out;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt          (w_cnt),
    .period_start (w_period_start)
  );

`ifdef PWM_SHADOW_DUTY_EN
  // Shadowed duty: load only at the period boundary so a period never mixes two values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act <= '0;
    end else if (w_period_start) begin
      r_duty_act <= duty;
    end
  end
`else
  // Direct duty: follow the input every clk, new value applies at the next compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act <= '0;
    end else begin
      r_duty_act <= duty;
    end
  end
`endif

  // Full-scale duty holds high through the last step instead of dipping low once per period
  assign w_pwm_raw = (r_duty_act == c_DUTY_FULL) || (w_cnt < r_duty_act);

  // Per-channel select: disabled -> 0, static mode -> 1, PWM mode -> shared waveform
  always_comb begin
    w_chan = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en_out[i]) begin
        w_chan[i] = 1'b0;
      end else if (!en_pwm[i]) begin
        w_chan[i] = 1'b1;
      end else begin
        w_chan[i] = w_pwm_raw;
      end
    end
  end

  // Output register: every enable or counter change appears one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_out <= '0;
    end else begin
      r_pwm_out <= w_chan;
    end
  end

  assign pwm_out      = r_pwm_out;
  assign period_start = w_period_start;

endmodule
`default_nettype wire
